// File: rtl/ioctl_upload_reader.sv
// rtl/ioctl_upload_reader.sv - Wishbone read master serving hps_io upload reads from SDRAM
module ioctl_upload_reader #(
    parameter logic [7:0]  INDEX     = 8'd1,
    parameter logic [25:0] BASE_ADDR = 26'h400000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        arb_req,
    input  logic        arb_gnt,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [25:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        rd_error
);

    // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUS  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   cache;
    logic [25:0]   tag;
    logic          cache_valid;
    logic [25:0]   lat_wa;
    logic          lat_half;
    logic [TW-1:0] tmo_cnt;
    logic          upload_d;
    logic [7:0]    index_d;
    logic          stale;

    logic          active;
    logic [25:0]   wa;
    logic          hit;
    logic          sess_end;
    logic          up_rise;
    logic          tmo_hit;
    logic          unused_addr_bits;

    assign active   = ioctl_upload && (ioctl_index == INDEX);
    // Bit 24 and bit 0 of the byte address do not take part in the word address.
    assign wa       = BASE_ADDR + {2'b00, ioctl_addr[23:2], 2'b00};
    assign hit      = cache_valid && (tag == wa);
    assign sess_end = (upload_d && !ioctl_upload) || (ioctl_index != index_d);
    assign up_rise  = ioctl_upload && !upload_d;
    assign tmo_hit  = (state == BUS) && !wb_ack && (tmo_cnt == TMO_LAST);
    assign wb_we    = 1'b0;
    assign unused_addr_bits = ^{ioctl_addr[24], ioctl_addr[0]};

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus/handshake outputs, all decoded from the current state.
    always_comb begin
        state_next = state;
        ioctl_wait = 1'b0;
        arb_req    = 1'b0;
        wb_cyc     = 1'b0;
        wb_stb     = 1'b0;
        wb_sel     = 4'h0;
        wb_adr     = 26'h0;
        case (state)
            IDLE: begin
                if (ioctl_rd && active && !hit) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                ioctl_wait = 1'b1;
                arb_req    = 1'b1;
                if (sess_end) begin
                    state_next = IDLE;
                end else if (arb_gnt) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                ioctl_wait = 1'b1;
                arb_req    = 1'b1;
                wb_cyc     = 1'b1;
                wb_stb     = 1'b1;
                wb_sel     = 4'hF;
                wb_adr     = lat_wa;
                if (wb_ack || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ioctl_wait = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: cache, latched request, timeout counter, read data and error flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cache       <= 32'h0;
            tag         <= 26'h0;
            cache_valid <= 1'b0;
            lat_wa      <= 26'h0;
            lat_half    <= 1'b0;
            tmo_cnt     <= '0;
            upload_d    <= 1'b0;
            index_d     <= 8'h0;
            stale       <= 1'b0;
            ioctl_din   <= 16'h0000;
            rd_error    <= 1'b0;
        end else begin
            upload_d <= ioctl_upload;
            index_d  <= ioctl_index;
            case (state)
                IDLE: begin
                    stale <= 1'b0;
                    if (ioctl_rd && active) begin
                        if (hit) begin
                            ioctl_din <= ioctl_addr[1] ? cache[31:16] : cache[15:0];
                        end else begin
                            lat_wa   <= wa;
                            lat_half <= ioctl_addr[1];
                        end
                    end
                end
                REQ: begin
                    if (arb_gnt) begin
                        tmo_cnt <= '0;
                    end
                end
                BUS: begin
                    // A session change during the cycle lets it finish but must not revalidate the cache.
                    if (sess_end || up_rise) begin
                        stale <= 1'b1;
                    end
                    if (wb_ack) begin
                        cache       <= wb_dat_i;
                        tag         <= lat_wa;
                        cache_valid <= !stale;
                        ioctl_din   <= lat_half ? wb_dat_i[31:16] : wb_dat_i[15:0];
                    end else if (tmo_cnt == TMO_LAST) begin
                        ioctl_din   <= 16'hDEAD;
                        rd_error    <= 1'b1;
                        cache_valid <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
            if (sess_end || up_rise) begin
                cache_valid <= 1'b0;
            end
            if (up_rise) begin
                rd_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb/tb_ioctl_upload_reader.sv - self-checking bench for ioctl_upload_reader
module tb_ioctl_upload_reader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = 25'h0;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        arb_req;
    logic        arb_gnt = 1'b0;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [25:0] wb_adr;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack = 1'b0;
    logic        rd_error;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    logic gnt_en = 1'b1;
    logic ack_en = 1'b1;

    ioctl_upload_reader #(
        .INDEX(8'd1),
        .BASE_ADDR(26'h400000),
        .TIMEOUT(8)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait),
        .arb_req(arb_req),
        .arb_gnt(arb_gnt),
        .wb_cyc(wb_cyc),
        .wb_stb(wb_stb),
        .wb_we(wb_we),
        .wb_sel(wb_sel),
        .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack),
        .rd_error(rd_error)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [31:0] mem_word(input logic [25:0] a);
        case (a)
            26'h400000: mem_word = 32'h11223344;
            26'h400004: mem_word = 32'h55667788;
            26'h400008: mem_word = 32'h99AABBCC;
            default:    mem_word = 32'hA5A55A5A;
        endcase
    endfunction

    // Arbiter and SDRAM slave: respond shortly after each rising edge.
    always begin
        @(posedge clk_sys);
        #2;
        arb_gnt = arb_req && gnt_en;
        if (wb_cyc && wb_stb && !wb_ack && ack_en) begin
            wb_ack   = 1'b1;
            wb_dat_i = mem_word(wb_adr);
        end else begin
            wb_ack = 1'b0;
        end
    end

    task automatic issue_rd(input logic [24:0] a);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_done(output int wcyc, output int stb_cyc, output logic saw_cyc,
                             output logic [25:0] adr, output logic to);
        wcyc = 0; stb_cyc = 0; saw_cyc = 1'b0; adr = 26'h0; to = 1'b0;
        while (ioctl_wait) begin
            wcyc++;
            if (wb_stb) begin
                stb_cyc++;
                saw_cyc = 1'b1;
                adr = wb_adr;
            end
            if (wcyc > 200) begin
                to = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic check_din(input string name);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, din=%h", name, ioctl_din);
        end else begin
            e = exp_q.pop_front();
            if (ioctl_din !== e) begin
                errors++;
                $display("FAIL %s: din=%h expected %h", name, ioctl_din, e);
            end
        end
    endtask

    task automatic check_to(input string name, input logic to);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL %s: ioctl_wait never fell (got timeout=%0d, expected 0)", name, to);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        checks++; if (ioctl_din !== 16'h0000) begin errors++; $display("FAIL reset_din: %h expected 0000", ioctl_din); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: %b expected 0", ioctl_wait); end
        checks++; if (arb_req !== 1'b0) begin errors++; $display("FAIL reset_req: %b expected 0", arb_req); end
        checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin errors++; $display("FAIL reset_wb: cyc/stb/we=%b expected 000", {wb_cyc, wb_stb, wb_we}); end
        checks++; if (wb_sel !== 4'h0 || wb_adr !== 26'h0) begin errors++; $display("FAIL reset_sel_adr: sel=%h adr=%h expected 0/0", wb_sel, wb_adr); end
        checks++; if (rd_error !== 1'b0) begin errors++; $display("FAIL reset_err: %b expected 0", rd_error); end
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_index  = 8'd1;
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_miss();
        int wcyc, stb_cyc; logic saw, to; logic [25:0] adr;
        exp_q.push_back(16'h3344);
        issue_rd(25'h0);
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL miss_we: %b expected 0", wb_we); end
        wait_done(wcyc, stb_cyc, saw, adr, to);
        check_to("miss_done", to);
        checks++; if (wcyc != 3) begin errors++; $display("FAIL miss_wait_len: %0d expected 3", wcyc); end
        checks++; if (adr !== 26'h400000) begin errors++; $display("FAIL miss_adr: %h expected 400000", adr); end
        check_din("miss_din");
    endtask

    task automatic test_hit();
        int wcyc, stb_cyc; logic saw, to; logic [25:0] adr;
        exp_q.push_back(16'h1122);
        issue_rd(25'h2);
        check_din("hit_din");
        wait_done(wcyc, stb_cyc, saw, adr, to);
        checks++; if (wcyc != 0 || saw !== 1'b0) begin errors++; $display("FAIL hit_no_bus: wait=%0d cyc=%b expected 0/0", wcyc, saw); end
        @(negedge clk_sys);
        checks++; if (ioctl_wait !== 1'b0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL hit_idle: wait=%b cyc=%b expected 0/0", ioctl_wait, wb_cyc); end
    endtask

    task automatic test_grant_delay();
        int wcyc, stb_cyc; logic saw, to, bad; logic [25:0] adr;
        gnt_en = 1'b0;
        bad = 1'b0;
        exp_q.push_back(16'h7788);
        issue_rd(25'h4);
        for (int i = 0; i < 10; i++) begin
            if (arb_req !== 1'b1 || wb_stb !== 1'b0 || ioctl_wait !== 1'b1) bad = 1'b1;
            @(negedge clk_sys);
        end
        checks++; if (bad) begin errors++; $display("FAIL gnt_hold: req=%b stb=%b expected 1/0 while ungranted", arb_req, wb_stb); end
        gnt_en = 1'b1;
        wait_done(wcyc, stb_cyc, saw, adr, to);
        check_to("gnt_done", to);
        checks++; if (adr !== 26'h400004) begin errors++; $display("FAIL gnt_adr: %h expected 400004", adr); end
        check_din("gnt_din");
    endtask

    task automatic test_timeout();
        int wcyc, stb_cyc; logic saw, to; logic [25:0] adr;
        ack_en = 1'b0;
        exp_q.push_back(16'hDEAD);
        issue_rd(25'h8);
        wait_done(wcyc, stb_cyc, saw, adr, to);
        ack_en = 1'b1;
        check_to("tmo_done", to);
        checks++; if (stb_cyc != 8) begin errors++; $display("FAIL tmo_bus_len: %0d expected 8", stb_cyc); end
        check_din("tmo_din");
        checks++; if (rd_error !== 1'b1) begin errors++; $display("FAIL tmo_err_set: %b expected 1", rd_error); end
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++; if (rd_error !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: %b expected 1", rd_error); end
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        checks++; if (rd_error !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: %b expected 0", rd_error); end
    endtask

    task automatic test_other_index();
        logic [15:0] din0;
        logic bad;
        bad = 1'b0;
        ioctl_index = 8'd2;
        @(negedge clk_sys);
        din0 = ioctl_din;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 25'(i * 2);
            ioctl_rd = 1'b1;
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            repeat (2) begin
                if (arb_req !== 1'b0 || ioctl_wait !== 1'b0 || wb_cyc !== 1'b0) bad = 1'b1;
                @(negedge clk_sys);
            end
        end
        checks++; if (bad) begin errors++; $display("FAIL idx_no_req: req=%b wait=%b expected 0/0", arb_req, ioctl_wait); end
        checks++; if (ioctl_din !== din0) begin errors++; $display("FAIL idx_din: %h expected %h", ioctl_din, din0); end
        ioctl_index = 8'd1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_abort();
        int wcyc, stb_cyc; logic saw, to; logic [25:0] adr;
        exp_q.push_back(16'h3344);
        issue_rd(25'h0);
        wait_done(wcyc, stb_cyc, saw, adr, to);
        check_to("abort_prime", to);
        check_din("abort_prime_din");
        gnt_en = 1'b0;
        issue_rd(25'h4);
        checks++; if (arb_req !== 1'b1) begin errors++; $display("FAIL abort_in_req: req=%b expected 1", arb_req); end
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        checks++; if (arb_req !== 1'b0 || ioctl_wait !== 1'b0) begin errors++; $display("FAIL abort_drop: req=%b wait=%b expected 0/0", arb_req, ioctl_wait); end
        gnt_en = 1'b1;
        repeat (2) @(negedge clk_sys);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        exp_q.push_back(16'h1122);
        issue_rd(25'h2);
        wait_done(wcyc, stb_cyc, saw, adr, to);
        check_to("abort_next", to);
        checks++; if (saw !== 1'b1 || wcyc != 3) begin errors++; $display("FAIL abort_cache_miss: cyc=%b wait=%0d expected 1/3", saw, wcyc); end
        check_din("abort_next_din");
    endtask

    task automatic test_high_addr();
        int wcyc, stb_cyc; logic saw, to; logic [25:0] adr;
        exp_q.push_back(16'h5566);
        issue_rd(25'h1000006);
        wait_done(wcyc, stb_cyc, saw, adr, to);
        check_to("hi_done", to);
        checks++; if (adr !== 26'h400004) begin errors++; $display("FAIL hi_adr: %h expected 400004", adr); end
        check_din("hi_din");
        exp_q.push_back(16'h7788);
        issue_rd(25'h1000004);
        check_din("hi_hit_din");
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL hi_hit_wait: %b expected 0", ioctl_wait); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_grant_delay();
        test_timeout();
        test_other_index();
        test_abort();
        test_high_addr();
        repeat (3) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
